// File: rtl/multi_clk_gen_pkg.sv
// Shared widths, types and standard divisor constants for multi_clk_gen.
// The divisor constants assume a 100 MHz system clock.
package multi_clk_gen_pkg;

  localparam int DEF_DIV_W  = 16;
  localparam int DEF_FRAC_W = 4;
  localparam int MAX_CH     = 8;

  typedef logic [DEF_DIV_W-1:0]  div_t;
  typedef logic [DEF_FRAC_W-1:0] frac_t;

  localparam div_t BAUD_9600_16X = 16'd651;
  localparam div_t SAMPLE_8K     = 16'd12500;
  localparam div_t PIX_25M       = 16'd4;

endpackage

// File: rtl/multi_clk_gen_ch.sv
// One divider channel: counter, shadow/commit of the divisor, tick and clk_out.
// MULTI_CLK_GEN_FRAC_DIV_EN adds a fractional accumulator stretching some periods by one cycle.
module clk_gen_ch
  import multi_clk_gen_pkg::*;
#(
  parameter int               DIV_W   = DEF_DIV_W,
  parameter int               FRAC_W  = DEF_FRAC_W,
  parameter logic [DIV_W-1:0] RST_DIV = DIV_W'(4)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_sync,
  input  logic              i_wr,
  input  logic [DIV_W-1:0]  i_wr_div,
  input  logic [FRAC_W-1:0] i_wr_frac,
  output logic              o_tick,
  output logic              o_clk_out,
  output logic              o_upd_pend
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_shadow;
  logic             r_pend;
  logic             r_tick;
  logic             r_clk_out;

  logic             w_run;
  logic             w_wrap;
  logic             w_commit;
  logic             w_load;
  logic             w_extra;
  logic [DIV_W-1:0] w_term;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic [DIV_W-1:0] w_div_nxt;
  logic             w_clk_nxt;

`ifdef MULTI_CLK_GEN_FRAC_DIV_EN
  logic [FRAC_W-1:0] r_frac;
  logic [FRAC_W-1:0] r_frac_sh;
  logic [FRAC_W-1:0] r_acc;
  logic              r_extra;

  assign w_extra = r_extra;
`else
  logic w_unused_frac;

  assign w_unused_frac = ^i_wr_frac;
  assign w_extra       = 1'b0;
`endif

  // A carried accumulator lengthens the current period to div+1 cycles.
  assign w_term = w_extra ? r_div : r_div - DIV_W'(1);

  always_comb begin
    w_run    = i_en && (r_div != '0);
    w_wrap   = w_run && (r_cnt == w_term);
    // A stopped or disabled channel has no period to protect, so it commits at once.
    w_commit = i_sync || w_wrap || !w_run;
    w_load   = w_commit && (i_wr || r_pend);
    w_div_nxt = r_div;
    if (w_load) begin
      w_div_nxt = i_wr ? i_wr_div : r_shadow;
    end
    w_cnt_nxt = w_commit ? '0 : r_cnt + DIV_W'(1);
    w_clk_nxt = 1'b0;
    if (!i_sync && w_run) begin
      w_clk_nxt = (w_cnt_nxt < (w_div_nxt >> 1));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_div     <= RST_DIV;
      r_shadow  <= RST_DIV;
      r_pend    <= 1'b0;
      r_tick    <= 1'b0;
      r_clk_out <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_div     <= w_div_nxt;
      r_tick    <= w_wrap && !i_sync;
      r_clk_out <= w_clk_nxt;
      if (w_load) begin
        r_pend <= 1'b0;
      end else if (i_wr) begin
        r_pend   <= 1'b1;
        r_shadow <= i_wr_div;
      end
    end
  end

`ifdef MULTI_CLK_GEN_FRAC_DIV_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frac    <= '0;
      r_frac_sh <= '0;
      r_acc     <= '0;
      r_extra   <= 1'b0;
    end else begin
      if (w_load) begin
        r_frac <= i_wr ? i_wr_frac : r_frac_sh;
      end
      if (i_wr && !w_commit) begin
        r_frac_sh <= i_wr_frac;
      end
      if (i_sync || w_load) begin
        r_acc   <= '0;
        r_extra <= 1'b0;
      end else if (w_wrap) begin
        {r_extra, r_acc} <= {1'b0, r_acc} + {1'b0, r_frac};
      end
    end
  end
`endif

  assign o_tick     = r_tick;
  assign o_clk_out  = r_clk_out;
  assign o_upd_pend = r_pend;

endmodule

// File: rtl/multi_clk_gen.sv
// NUM_CH independent clock-enable generators with glitch-free divisor updates and phase sync.
// Optional fractional divisors: define MULTI_CLK_GEN_FRAC_DIV_EN.
module multi_clk_gen
  import multi_clk_gen_pkg::*;
#(
  parameter int                      NUM_CH  = 4,
  parameter int                      DIV_W   = DEF_DIV_W,
  parameter logic [NUM_CH*DIV_W-1:0] RST_DIV = {16'd4, 16'd12500, 16'd32, 16'd20833},
  parameter int                      FRAC_W  = DEF_FRAC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_i,
  input  logic              wr_en,
  input  logic [2:0]        wr_ch,
  input  logic [DIV_W-1:0]  wr_div,
  input  logic [FRAC_W-1:0] wr_frac,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] upd_pend,
  output logic              wr_err
);

  logic [NUM_CH-1:0] w_wr_sel;
  logic              w_ch_bad;
  logic              r_wr_err;

  // wr_en is a single-cycle strobe; wr_ch/wr_div/wr_frac are only sampled while it is high.
  always_comb begin
    w_ch_bad = ({1'b0, wr_ch} >= 4'(NUM_CH));
    for (int i = 0; i < NUM_CH; i++) begin
      w_wr_sel[i] = wr_en && (wr_ch == 3'(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= wr_en && w_ch_bad;
    end
  end

  assign wr_err = r_wr_err;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_gen_ch #(
      .DIV_W  (DIV_W),
      .FRAC_W (FRAC_W),
      .RST_DIV(RST_DIV[g*DIV_W +: DIV_W])
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_en      (ch_en[g]),
      .i_sync    (sync_i),
      .i_wr      (w_wr_sel[g]),
      .i_wr_div  (wr_div),
      .i_wr_frac (wr_frac),
      .o_tick    (tick[g]),
      .o_clk_out (clk_out[g]),
      .o_upd_pend(upd_pend[g])
    );
  end

endmodule

// File: tb/tb_multi_clk_gen.sv
// Directed bench for multi_clk_gen: per-cycle vector table plus sync, enable, reset
// and (with MULTI_CLK_GEN_FRAC_DIV_EN) fractional-period sequences.
module tb_multi_clk_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ch_en;
  logic        sync_i;
  logic        wr_en;
  logic [2:0]  wr_ch;
  logic [15:0] wr_div;
  logic [3:0]  wr_frac;
  logic [3:0]  tick;
  logic [3:0]  clk_out;
  logic [3:0]  upd_pend;
  logic        wr_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        wr;
    logic [2:0]  ch;
    logic [15:0] div;
    logic        t3;
    logic        c3;
    logic        p3;
    logic        err;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];

  multi_clk_gen dut (
    .clk     (clk),
    .rst     (rst),
    .ch_en   (ch_en),
    .sync_i  (sync_i),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_div  (wr_div),
    .wr_frac (wr_frac),
    .tick    (tick),
    .clk_out (clk_out),
    .upd_pend(upd_pend),
    .wr_err  (wr_err)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic [2:0] ch, input logic [15:0] div,
                     input logic t3, input logic c3, input logic p3, input logic err);
    vec_t v;
    v.wr = wr; v.ch = ch; v.div = div;
    v.t3 = t3; v.c3 = c3; v.p3 = p3; v.err = err;
    vecs.push_back(v);
  endtask

  initial begin
    int w;
    int gap;
    int want;

    rst = 1'b0; ch_en = 4'hF; sync_i = 1'b0;
    wr_en = 1'b0; wr_ch = '0; wr_div = '0; wr_frac = '0;

    // Reset state
    repeat (3) step();
    check("rst_tick", tick, 0);
    check("rst_clk_out", clk_out, 0);
    check("rst_upd_pend", upd_pend, 0);
    check("rst_wr_err", wr_err, 0);

    // Vector table, one row per cycle after reset release (ch3 default div 4)
    for (int n = 1; n <= 12; n++) begin
      add(0, 0, 0, (n % 4 == 0), (n % 4 == 0) || (n % 4 == 1), 0, 0);
    end
    add(0, 0, 0, 0, 1, 0, 0); // 13
    add(1, 3, 6, 0, 0, 1, 0); // 14: write div 6 mid-period
    add(0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 1, 0, 0); // 16: commit at wrap
    add(0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0); // 22
    add(0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0); // 28
    add(1, 3, 0, 0, 1, 1, 0); // 29: write div 0
    add(0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0); // 34: last tick, now stopped
    add(0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    add(1, 3, 1, 0, 0, 0, 0); // 37: div 1 on a stopped channel
    add(0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0);
    add(1, 3, 4, 1, 1, 0, 0); // 41: write at wrap
    add(0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    add(1, 3, 3, 1, 1, 0, 0); // 45: write at wrap
    add(0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0);
    add(1, 6, 9, 0, 0, 0, 1); // 49: invalid channel
    add(0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0); // 51

    rst = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      wr_en  = vecs[i].wr;
      wr_ch  = vecs[i].ch;
      wr_div = vecs[i].div;
      step();
      wr_en = 1'b0;
      check($sformatf("tick3@%0d", i + 1), tick[3], vecs[i].t3);
      check($sformatf("clk3@%0d", i + 1), clk_out[3], vecs[i].c3);
      check($sformatf("pend@%0d", i + 1), upd_pend, {vecs[i].p3, 3'b000});
      check($sformatf("wr_err@%0d", i + 1), wr_err, vecs[i].err);
      check($sformatf("tick210@%0d", i + 1), tick[2:0], (i + 1 == 32) ? 3'b010 : 3'b000);
    end

    // Sync: ch0 div 5 and ch1 div 7 pending, sync lands on a ch3 wrap
    wr_en = 1'b1; wr_ch = 3'd0; wr_div = 16'd5;
    step();
    check("sync_pend0", upd_pend, 4'b0001);
    wr_ch = 3'd1; wr_div = 16'd7;
    step();
    wr_en = 1'b0;
    check("sync_pend01", upd_pend, 4'b0011);
    sync_i = 1'b1;
    step();
    sync_i = 1'b0;
    check("sync_no_tick", tick, 0);
    check("sync_commit", upd_pend, 0);
    for (int k = 1; k <= 35; k++) begin
      step();
      check($sformatf("sync_t0@%0d", k), tick[0], (k % 5 == 0));
      check($sformatf("sync_t1@%0d", k), tick[1], (k % 7 == 0));
      check($sformatf("sync_t3@%0d", k), tick[3], (k % 3 == 0));
    end

    // ch_en: disable on a would-be wrap, commit while disabled, re-enable
    ch_en[3] = 1'b0;
    step();
    check("dis_tick", tick[3], 0);
    check("dis_clk", clk_out[3], 0);
    wr_en = 1'b1; wr_ch = 3'd3; wr_div = 16'd2;
    step();
    wr_en = 1'b0;
    check("dis_commit", upd_pend[3], 0);
    step();
    check("dis_tick2", tick[3], 0);
    ch_en[3] = 1'b1;
    exp_q.push_back(8'd0); exp_q.push_back(8'd1);
    exp_q.push_back(8'd0); exp_q.push_back(8'd1);
    while (exp_q.size() > 0) begin
      want = int'(exp_q.pop_front());
      step();
      check("en_tick", tick[3], want);
      check("en_clk", clk_out[3], want);
    end

`ifdef MULTI_CLK_GEN_FRAC_DIV_EN
    ch_en[3] = 1'b0;
    wr_en = 1'b1; wr_ch = 3'd3; wr_div = 16'd4; wr_frac = 4'd8;
    step();
    wr_en = 1'b0; wr_frac = '0;
    check("frac_commit", upd_pend[3], 0);
    ch_en[3] = 1'b1;
    w = 0;
    do begin
      step();
      w++;
    end while (!tick[3] && w < 10);
    check("frac_first", w, 4);
    exp_q.push_back(8'd4); exp_q.push_back(8'd5);
    exp_q.push_back(8'd4); exp_q.push_back(8'd5);
    while (exp_q.size() > 0) begin
      want = int'(exp_q.pop_front());
      gap = 0;
      do begin
        step();
        gap++;
      end while (!tick[3] && gap < 20);
      check("frac_gap", gap, want);
    end
`endif

    // Async reset mid-period with a pending write outstanding
    wr_en = 1'b1; wr_ch = 3'd2; wr_div = 16'd9;
    step();
    wr_en = 1'b0;
    check("pre_rst_pend", upd_pend, 4'b0100);
    #3;
    rst = 1'b0;
    #1;
    check("arst_tick", tick, 0);
    check("arst_clk", clk_out, 0);
    check("arst_pend", upd_pend, 0);
    check("arst_err", wr_err, 0);
    step();
    step();
    rst = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step();
      check($sformatf("rel_t3@%0d", k), tick[3], (k % 4 == 0));
      check($sformatf("rel_c3@%0d", k), clk_out[3], (k % 4 == 0) || (k % 4 == 1));
      check($sformatf("rel_t1@%0d", k), tick[1], (k == 32));
      check($sformatf("rel_t2@%0d", k), tick[2], 0);
    end
    check("rel_pend", upd_pend, 0);

    // Report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
